// File: rtl/hb_dn2_if.sv
// Sample-in / decimated-sample-out bundle for hb_dn2; master drives samples, slave is the filter.
interface hb_dn2_if #(
  parameter int XIN_WIDTH  = 16,
  parameter int YOUT_WIDTH = 16
);
  logic signed [XIN_WIDTH-1:0]  xin;
  logic                         xin_valid;
  logic                         xin_sync;
  logic signed [YOUT_WIDTH-1:0] yout;
  logic                         yout_valid;
  logic                         ovf;

  modport master (output xin, xin_valid, xin_sync, input yout, yout_valid, ovf);
  modport slave  (input xin, xin_valid, xin_sync, output yout, yout_valid, ovf);
endinterface

// File: rtl/hb_dn2.sv
// Half-band decimate-by-2 FIR: 4-stage pipeline (pre-add, multiply, sum, round/saturate), no backpressure.
// Define HB_DN2_STICKY_OVF_EN to make ovf sticky until reset instead of a per-output pulse.
module hb_dn2 #(
  parameter int XIN_WIDTH      = 16,
  parameter int COE_WIDTH      = 16,
  parameter int NUM_UNIQUE_COE = 5,
  parameter logic [NUM_UNIQUE_COE*COE_WIDTH-1:0] COE_NUMS =
    {16'h01dc, 16'hfcdb, 16'h0609, 16'hf3c6, 16'h2847},
  parameter int YOUT_WIDTH     = 16,
  parameter int SRA_BITS       = 15
) (
  input logic      clk,
  input logic      rst_n,
  hb_dn2_if.slave  bus
);
  localparam int N  = NUM_UNIQUE_COE;
  localparam int PW = XIN_WIDTH + 1;
  localparam int MW = XIN_WIDTH + COE_WIDTH + 1;
  localparam int AW = XIN_WIDTH + COE_WIDTH + 4;
  localparam logic signed [AW-1:0] RND  = AW'(1) <<< (SRA_BITS - 1);
  localparam logic signed [AW-1:0] YMAX = (AW'(1) <<< (YOUT_WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] YMIN = -(AW'(1) <<< (YOUT_WIDTH - 1));

  function automatic logic signed [COE_WIDTH-1:0] coe(input int j);
    return COE_NUMS[(N-1-j)*COE_WIDTH +: COE_WIDTH];
  endfunction

  logic                        phase;
  logic                        ph_in;
  logic signed [XIN_WIDTH-1:0] ev [N];
  logic signed [XIN_WIDTH-1:0] od [2*N];
  logic                        v0, v1, v2, v3;
  logic signed [PW-1:0]        pre [N];
  logic signed [XIN_WIDTH-1:0] ctr;
  logic signed [MW-1:0]        prod [N];
  logic signed [AW-1:0]        cen;
  logic signed [AW-1:0]        sum;
  logic signed [AW-1:0]        acc;
  logic signed [AW-1:0]        rnd;
  logic signed [AW-1:0]        sh;
  logic                        hi, lo;

  // A sync strobe forces its sample into phase 0, abandoning any half-built pair.
  assign ph_in = bus.xin_sync ? 1'b0 : phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      v0    <= 1'b0;
      for (int i = 0; i < N; i++)   ev[i] <= '0;
      for (int i = 0; i < 2*N; i++) od[i] <= '0;
    end else begin
      v0 <= bus.xin_valid & ph_in;
      if (bus.xin_valid) begin
        phase <= ~ph_in;
        if (ph_in) begin
          od[0] <= bus.xin;
          for (int i = 1; i < 2*N; i++) od[i] <= od[i-1];
        end else begin
          ev[0] <= bus.xin;
          for (int i = 1; i < N; i++) ev[i] <= ev[i-1];
        end
      end
    end
  end

  // Odd line holds the 2N outer taps (folded pairwise); even line's oldest entry is the centre tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      ctr <= '0;
      for (int j = 0; j < N; j++) pre[j] <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        ctr <= ev[N-1];
        for (int j = 0; j < N; j++) pre[j] <= PW'(od[j]) + PW'(od[2*N-1-j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      cen <= '0;
      for (int j = 0; j < N; j++) prod[j] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        cen <= AW'(ctr) <<< (SRA_BITS - 1);
        for (int j = 0; j < N; j++) prod[j] <= MW'(pre[j]) * MW'(coe(j));
      end
    end
  end

  always_comb begin
    sum = cen;
    for (int j = 0; j < N; j++) sum = sum + AW'(prod[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      acc <= '0;
    end else begin
      v3 <= v2;
      if (v2) acc <= sum;
    end
  end

  always_comb begin
    rnd = acc + RND;
    sh  = rnd >>> SRA_BITS;
    hi  = (sh > YMAX);
    lo  = (sh < YMIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.yout       <= '0;
      bus.yout_valid <= 1'b0;
      bus.ovf        <= 1'b0;
    end else begin
      bus.yout_valid <= v3;
      if (v3) begin
        bus.yout <= hi ? YMAX[YOUT_WIDTH-1:0] :
                    lo ? YMIN[YOUT_WIDTH-1:0] : sh[YOUT_WIDTH-1:0];
      end
`ifdef HB_DN2_STICKY_OVF_EN
      if (v3 && (hi || lo)) bus.ovf <= 1'b1;
`else
      bus.ovf <= v3 & (hi | lo);
`endif
    end
  end
endmodule

// File: tb/tb_hb_dn2.sv
// Directed-vector bench for hb_dn2: impulses, DC/saturation, gaps, sync realignment, mid-stream reset.
module tb_hb_dn2;
  localparam int DC = 99999;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total, bad;
  bit   ph;

  int q_y[$], q_o[$], q_c[$], acc_q[$];
  int ey[$], eo[$];

  hb_dn2_if #(.XIN_WIDTH(16), .YOUT_WIDTH(16)) bus ();

  hb_dn2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.yout_valid) begin
      q_y.push_back(int'(bus.yout));
      q_o.push_back(int'(bus.ovf));
      q_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_y.delete(); q_o.delete(); q_c.delete(); acc_q.delete();
    ey.delete(); eo.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.xin_valid = 1'b0; bus.xin_sync = 1'b0; bus.xin = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ph = 1'b0;
    clear_q();
  endtask

  task automatic send(input int x, input bit sy);
    @(negedge clk);
    bus.xin = 16'(x); bus.xin_valid = 1'b1; bus.xin_sync = sy;
    if (sy) ph = 1'b0;
    if (ph) acc_q.push_back(cyc + 1);
    ph = ~ph;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.xin_valid = 1'b0; bus.xin_sync = 1'b0;
    end
  endtask

  task automatic expect_y(input int y, input int o);
    ey.push_back(y); eo.push_back(o);
  endtask

  task automatic verify(input string nm);
    chk({nm, "_n"}, q_y.size(), ey.size());
    for (int i = 0; i < q_y.size() && i < ey.size(); i++) begin
      if (ey[i] != DC) begin
        chk($sformatf("%s_y%0d", nm, i), q_y[i], ey[i]);
        chk($sformatf("%s_ovf%0d", nm, i), q_o[i], eo[i]);
      end
      if (i < acc_q.size()) chk($sformatf("%s_lat%0d", nm, i), q_c[i] - acc_q[i], 4);
    end
  endtask

  task automatic odd_impulse(input string nm);
    send(16384, 1'b0);
    for (int i = 1; i < 20; i++) send(0, 1'b0);
    idle(8);
    for (int m = 0; m < 10; m++) expect_y((m == 4) ? 8192 : 0, 0);
    verify(nm);
  endtask

  task automatic even_expect();
    expect_y(238, 0);  expect_y(-402, 0);  expect_y(773, 0);  expect_y(-1565, 0);
    expect_y(5156, 0); expect_y(5156, 0);  expect_y(-1565, 0); expect_y(773, 0);
    expect_y(-402, 0); expect_y(238, 0);   expect_y(0, 0);
  endtask

  task automatic dc_run(input string nm, input int x, input int y0, input int yss, input int o);
    for (int i = 0; i < 24; i++) send(x, 1'b0);
    idle(8);
    expect_y(y0, 0);
    for (int m = 1; m < 10; m++) expect_y(DC, 0);
    expect_y(yss, o); expect_y(yss, o);
    verify(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; ph = 1'b0;
    bus.xin = '0; bus.xin_valid = 1'b0; bus.xin_sync = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_yout", int'(bus.yout), 0);
    chk("rst_vld", int'(bus.yout_valid), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    do_reset();

    odd_impulse("odd");

    do_reset();
    send(0, 1'b0); send(16384, 1'b0);
    for (int i = 2; i < 22; i++) send(0, 1'b0);
    idle(8);
    even_expect();
    verify("even");

    do_reset();
    dc_run("dc1000", 1000, 15, 1013, 0);
    do_reset();
    dc_run("dcmax", 32767, 476, 32767, 1);
    do_reset();
    dc_run("dcmin", -32768, -476, -32768, 1);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      send((i == 1) ? 16384 : 0, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(8);
    even_expect();
    verify("gap");

    // Sync on a would-be phase-1 sample: that pair yields nothing.
    do_reset();
    send(0, 1'b0); send(0, 1'b0); send(0, 1'b0);
    send(0, 1'b1); send(16384, 1'b0); send(0, 1'b0); send(0, 1'b0);
    idle(8);
    expect_y(0, 0); expect_y(238, 0); expect_y(-402, 0);
    verify("sync");

    do_reset();
    send(0, 1'b0); send(16384, 1'b0);
    for (int i = 2; i < 8; i++) send(0, 1'b0);
    idle(2);
    chk("pre_rst_y", int'(bus.yout), -402);
    clear_q();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y", int'(bus.yout), 0);
    chk("mid_rst_vld", int'(bus.yout_valid), 0);
    chk("mid_rst_ovf", int'(bus.ovf), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ph = 1'b0;
    idle(8);
    chk("stale_n", q_y.size(), 0);
    clear_q();
    odd_impulse("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
